// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART constants and FSM state encoding (TX and RX paths)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Line-protocol FSM states, shared with the receive path
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 100 MHz / 9600 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 10416;

  // 8N1 frame shape
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Brief    : Byte-push / serial-out bundle between core logic and the UART TX
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if;

  logic [7:0] data_in;
  logic       send;
  logic       clr;
  logic       tx;
  logic       busy;
  logic       idle;
  logic       overrun;
  logic       led_tx;

  // Core logic side: pushes bytes, observes status
  modport master (
    output data_in, send, clr,
    input  tx, busy, idle, overrun, led_tx
  );

  // Transmitter side
  modport slave (
    input  data_in, send, clr,
    output tx, busy, idle, overrun, led_tx
  );

endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : byte_fifo
//  Brief    : Small register-based FIFO; a push while full is accepted only
//             when a pop happens in the same cycle. Full flag is registered.
//  Revision : 1.0  initial release
// ============================================================================
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic [WIDTH-1:0]           wdata,
  output logic      [WIDTH-1:0]           rdata,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        full_q, full_d;
  logic                        push_ok;
  logic                        pop_ok;

  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && (!full_q || pop_ok);

  // Pointer, count and storage update; DEPTH is a power of 2 so pointers wrap naturally
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : 8N1 UART transmitter fed by a byte FIFO, back-to-back frames,
//             sticky overrun flag and a stretched TX activity LED.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int LED_HOLD     = 5000000
) (
  input  wire logic     clk_100,
  input  wire logic     rst,
  uart_tx_fifo_if.slave bus
);

  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int LW   = $clog2(LED_HOLD + 1);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e     state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [IW-1:0]   bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            idle_q, idle_d;
  logic            overrun_q, overrun_d;
  logic            led_q, led_d;
  logic [LW-1:0]   hold_q, hold_d;

  logic            fifo_pop;
  logic [7:0]      fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic            baud_end;

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_100),
    .rst   (rst),
    .push  (bus.send),
    .pop   (fifo_pop),
    .wdata (bus.data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  // FSM and shift datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next state: STOP pops the next byte on its last cycle so frames abut
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == IW'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from current state; everything below is registered next edge
  always_comb begin
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    idle_d = (state_q == IDLE) && (fifo_count == '0);
    led_d  = (state_q != IDLE) || (hold_q != '0);
    if (state_q != IDLE) begin
      hold_d = LW'(LED_HOLD);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else begin
      hold_d = '0;
    end
    // A new drop in the same cycle as clr keeps the flag set
    if (bus.send && fifo_full && !fifo_pop) begin
      overrun_d = 1'b1;
    end else if (bus.clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Glitch-free registered outputs
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      tx_q      <= 1'b1;
      idle_q    <= 1'b1;
      overrun_q <= 1'b0;
      led_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      tx_q      <= tx_d;
      idle_q    <= idle_d;
      overrun_q <= overrun_d;
      led_q     <= led_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = fifo_full;
  assign bus.idle    = idle_q;
  assign bus.overrun = overrun_q;
  assign bus.led_tx  = led_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Directed bench for uart_tx_fifo with a serial-decoding scoreboard
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int CPB  = 4;
  localparam int HOLD = 20;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   t;

  logic [7:0] exp_q[$];

  // Serial monitor state
  bit         m_hunt;
  int         m_cnt;
  logic [7:0] m_sh;

  uart_tx_fifo_if u_if ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .LED_HOLD     (HOLD)
  ) dut (
    .clk_100 (clk),
    .rst     (rst),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic step_to(input int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Drive one send strobe value for the coming edge and record the byte expected on the line
  task automatic put(input logic [7:0] b);
    u_if.send    = 1'b1;
    u_if.data_in = b;
    exp_q.push_back(b);
  endtask

  // After put(): advance to the negedge following the push edge, which becomes t=0
  task automatic mark_t0();
    @(negedge clk);
    t = 0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((u_if.idle !== 1'b1 || exp_q.size() != 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", (k < 2000), 1);
    repeat (30) @(negedge clk);
  endtask

  // Decode frames off the line: start detected at first low sample, bits sampled mid-period
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_hunt = 1'b1;
      m_cnt  = 0;
      exp_q.delete();
    end else if (m_hunt) begin
      if (u_if.tx === 1'b0) begin
        m_hunt = 1'b0;
        m_cnt  = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == CPB / 2) begin
        chk("rx_start_bit", u_if.tx, 0);
      end else if (m_cnt < 9 * CPB && ((m_cnt - CPB / 2) % CPB) == 0) begin
        m_sh = {u_if.tx, m_sh[7:1]};
      end else if (m_cnt == 9 * CPB + CPB / 2) begin
        chk("rx_stop_bit", u_if.tx, 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_byte: got %02h expected no frame", m_sh);
        end else begin
          chk("rx_byte", m_sh, exp_q.pop_front());
        end
        m_hunt = 1'b1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    n_cmp = 0;
    n_err = 0;
    t     = 0;
    rst   = 1'b1;
    u_if.send    = 1'b0;
    u_if.data_in = 8'h00;
    u_if.clr     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_tx", u_if.tx, 1);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_idle", u_if.idle, 1);
    chk("rst_overrun", u_if.overrun, 0);
    chk("rst_led", u_if.led_tx, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame 0x0F: latency, idle return and LED hold
    put(8'h0F);
    mark_t0();
    u_if.send = 1'b0;
    step_to(1);
    chk("lat_tx_t1", u_if.tx, 1);
    chk("led_t1", u_if.led_tx, 0);
    step_to(2);
    chk("lat_tx_t2", u_if.tx, 0);
    chk("led_t2", u_if.led_tx, 1);
    step_to(41);
    chk("idle_t41", u_if.idle, 0);
    step_to(42);
    chk("idle_t42", u_if.idle, 1);
    step_to(61);
    chk("led_t61", u_if.led_tx, 1);
    step_to(62);
    chk("led_t62", u_if.led_tx, 0);
    wait_done();

    // LED stays high when a new frame starts inside the hold window
    put(8'h81);
    mark_t0();
    u_if.send = 1'b0;
    ok = 1'b1;
    while (t < 60) begin
      @(negedge clk);
      t++;
      if (t >= 2 && u_if.led_tx !== 1'b1) ok = 1'b0;
      if (t == 49) put(8'h42);
      if (t == 50) u_if.send = 1'b0;
    end
    chk("led_continuous", ok, 1);
    step_to(111);
    chk("led2_t111", u_if.led_tx, 1);
    step_to(112);
    chk("led2_t112", u_if.led_tx, 0);
    wait_done();

    // Back-to-back A5, 3C with no gap between stop and next start
    put(8'hA5);
    mark_t0();
    put(8'h3C);
    step_to(1);
    u_if.send = 1'b0;
    step_to(2);
    chk("b2b_start1", u_if.tx, 0);
    step_to(41);
    chk("b2b_stop1", u_if.tx, 1);
    chk("b2b_idle", u_if.idle, 0);
    step_to(42);
    chk("b2b_start2", u_if.tx, 0);
    wait_done();

    // Fill, overrun, clear, then push exactly on the full-FIFO pop cycle
    put(8'h01);
    mark_t0();
    put(8'h02);
    step_to(1);
    put(8'h03);
    step_to(2);
    put(8'h04);
    step_to(3);
    chk("busy_t3", u_if.busy, 0);
    put(8'h05);
    step_to(4);
    chk("busy_t4", u_if.busy, 1);
    chk("ovr_t4", u_if.overrun, 0);
    u_if.send    = 1'b1;
    u_if.data_in = 8'h06;
    step_to(5);
    u_if.send = 1'b0;
    chk("ovr_t5", u_if.overrun, 1);
    step_to(7);
    u_if.clr = 1'b1;
    step_to(8);
    u_if.clr = 1'b0;
    chk("ovr_clr", u_if.overrun, 0);
    chk("busy_t8", u_if.busy, 1);
    step_to(40);
    chk("busy_t40", u_if.busy, 1);
    put(8'h07);
    step_to(41);
    u_if.send = 1'b0;
    chk("simul_busy", u_if.busy, 1);
    chk("simul_ovr", u_if.overrun, 0);
    wait_done();

    // Reset during data bit 3 of 0x55 with 0x66 still queued
    put(8'h55);
    mark_t0();
    put(8'h66);
    step_to(1);
    u_if.send = 1'b0;
    step_to(19);
    chk("mid_bit3", u_if.tx, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", u_if.tx, 1);
    chk("mid_rst_idle", u_if.idle, 1);
    chk("mid_rst_busy", u_if.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (u_if.tx !== 1'b1) ok = 1'b0;
    end
    chk("post_rst_quiet", ok, 1);
    chk("post_rst_idle", u_if.idle, 1);
    chk("post_rst_led", u_if.led_tx, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter with a small byte FIFO in front of it. It is the transmit-side counterpart to the existing 9600-baud receive path.
- The core logic pushes bytes with a one-cycle send strobe. The block serialises them LSB-first on tx, back-to-back, at CLKS_PER_BIT clocks per bit.
- It sits between the processor/IO logic and the board TX pin. It also drives the TX activity LED.

Parameters:
- CLKS_PER_BIT, 10416, clk_100 cycles per bit period (100 MHz / 9600 baud); legal range ≥ 4.
- FIFO_DEPTH, 4, byte entries; must be a power of 2, ≥ 2.
- LED_HOLD, 5000000, cycles led_tx stays high after the last frame ends (50 ms).

Ports:
- clk_100  in  1  system clock, 100 MHz, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  8  byte to enqueue, sampled when send=1.
- send  in  1  enqueue strobe, one byte per cycle high.
- clr  in  1  synchronous clear of the overrun flag.
- tx  out  1  serial line, idle high.
- busy  out  1  FIFO full; a send this cycle is dropped unless a pop occurs in the same cycle.
- idle  out  1  FIFO empty and FSM in IDLE.
- overrun  out  1  sticky; set when a send is dropped.
- led_tx  out  1  activity indicator.

Behaviour:
- Reset values (asynchronous):
  - tx=1, busy=0, idle=1, overrun=0, led_tx=0.
  - FIFO pointers/count=0, FSM=IDLE, bit counter=0, baud counter=0.
- Reset mid-frame: tx returns to 1 immediately, the current frame is aborted and the FIFO contents are discarded.
- FIFO:
  - Push on send && (!full || pop_this_cycle).
  - Pop when the FSM loads a byte.
  - Simultaneous push and pop with the FIFO full: both take effect and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - busy = (count == FIFO_DEPTH), registered from count.
- Overrun:
  - overrun is set on send && busy && !pop.
  - It is cleared on clr unless a new overrun occurs in the same cycle; set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is not empty, pop into shift register, baud counter=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the last cycle, if the FIFO is not empty, pop and go directly to START; otherwise go to IDLE.
  - There is no idle gap between queued frames.
- tx is driven from a register, so there are no combinational glitches.
- Latency: send at edge N with the block idle → byte written at edge N, popped at edge N+1, tx=0 from edge N+1+1.
  - Precisely: tx falls 2 cycles after the send edge.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at bit end.
  - Width is $clog2(CLKS_PER_BIT).
- idle = (state==IDLE) && (count==0).
- led_tx:
  - High whenever state!=IDLE.
  - After returning to IDLE, stays high for LED_HOLD cycles; the timer is reloaded by any new frame.
- data_in is ignored when send=0.
- Multi-cycle send high pushes one byte per cycle; this is caller responsibility.

Decomposition:
- A shared package uart_pkg holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - the default CLKS_PER_BIT=10416;
  - the frame constants (DATA_BITS=8, STOP_BITS=1).
  - The receiver uses the same package.
- One sub-module: byte_fifo (parameterised width/depth, push/pop/full/empty/count). The FSM and baud/LED counters stay in the top block.

Test Plan:
- Reset, then a single send of data_in=8'h0F (CLKS_PER_BIT=10416):
  - tx sequence is 0,1,1,1,1,0,0,0,0,1, each exactly 10416 cycles (the 10'b1000011110 frame LSB-first);
  - tx falls 2 cycles after send;
  - idle returns to 1 after 104160+2 cycles.
- Back-to-back (CLKS_PER_BIT=4): send 8'hA5 then 8'h3C on consecutive cycles → two frames with no idle cycle between stop and start; decoded bytes are A5, 3C.
- Full/overrun (CLKS_PER_BIT=4, FIFO_DEPTH=4): six consecutive sends 01..06 while idle:
  - byte 01 popped at once, 02..05 fill the FIFO, busy=1;
  - 06 dropped, overrun=1;
  - clr clears overrun;
  - line carries 01,02,03,04,05.
- Simultaneous push/pop at full: assert send exactly on the STOP last cycle with the FIFO full → byte accepted, overrun stays 0, count unchanged.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 in the same cycle, idle=1, FIFO empty, no further frames after rst deasserts.
- LED (LED_HOLD=20): one frame → led_tx high from start through 20 cycles after STOP ends, then 0; a second send within the hold window keeps led_tx continuously high.
